// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding control block:
// forward-select encodings, the per-stage tag record and the tag match helper.
package fwd_pkg;

  // Architectural register-address width carried in every tag
  localparam int FWD_REG_AW = 5;

  // EX-stage forwarding mux select encodings (2'b11 is never produced)
  localparam logic [1:0] FWD_ID_EX  = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;

  // Destination tag of one in-flight instruction
  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } fwd_tag_t;

  // True when the tagged instruction will write register src (x0 never matches)
  function automatic logic tag_hits(input fwd_tag_t t, input logic [FWD_REG_AW-1:0] src);
    return t.valid & t.regwrite & (t.rd != '0) & (t.rd == src);
  endfunction

endpackage

// File: rtl/fwd_tag_stage.sv
// One tag pipeline register: holds on hold_i, loads an all-zero bubble on
// bubble_i, otherwise captures tag_i. Reset clears the whole tag.
module fwd_tag_stage
  import fwd_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     hold_i,
  input  logic     bubble_i,
  input  fwd_tag_t tag_i,
  output fwd_tag_t tag_o
);

  fwd_tag_t tag_q;
  fwd_tag_t tag_d;

  // Next tag: keep on hold, clear fully on bubble so no stale rd lingers
  always_comb begin
    tag_d = tag_q;
    if (!hold_i) begin
      tag_d = bubble_i ? '0 : tag_i;
    end
  end

  // Tag register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_o = tag_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard control for the 5-stage core.
// Tracks ID/EX, EX/MEM and MEM/WB destination tags and drives the EX operand
// forward selects and the load-use stall. Optional build macro
// FWD_RF_BYPASS_EN enables the WB-to-ID register-file bypass selects;
// without it rfbypA_o/rfbypB_o are tied low.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  // Must match the tag width fixed in fwd_pkg
  parameter int REG_AW = FWD_REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  output logic [1:0]        forwardA_o,
  output logic [1:0]        forwardB_o,
  output logic              stall_o,
  output logic              rfbypA_o,
  output logic              rfbypB_o
);

  fwd_tag_t id_tag;
  fwd_tag_t idex_tag;
  fwd_tag_t exmem_tag;
  fwd_tag_t memwb_tag;
  logic     idex_bubble;
  logic     stall;

  // Index 0 is source 1 (operand A), index 1 is source 2 (operand B)
  logic [1:0][REG_AW-1:0] id_rs;
  logic [1:0][REG_AW-1:0] idex_rs_q;
  logic [1:0][REG_AW-1:0] idex_rs_d;
  logic [1:0][1:0]        fwd_sel;
  logic [1:0]             rfbyp;

  assign id_rs  = {id_rs2_i, id_rs1_i};
  assign id_tag = '{valid: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i, memread: id_memread_i};

  // Load in EX whose result the ID instruction needs cannot be forwarded in time
  assign stall = id_valid_i & idex_tag.valid & idex_tag.memread & (idex_tag.rd != '0) &
                 ((idex_tag.rd == id_rs1_i) | (idex_tag.rd == id_rs2_i));

  // Stall and flush together still insert only one bubble
  assign idex_bubble = stall | flush_i | ~id_valid_i;

  fwd_tag_stage u_idex (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (hold_i),
    .bubble_i (idex_bubble),
    .tag_i    (id_tag),
    .tag_o    (idex_tag)
  );

  fwd_tag_stage u_exmem (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (hold_i),
    .bubble_i (1'b0),
    .tag_i    (idex_tag),
    .tag_o    (exmem_tag)
  );

  fwd_tag_stage u_memwb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (hold_i),
    .bubble_i (1'b0),
    .tag_i    (exmem_tag),
    .tag_o    (memwb_tag)
  );

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_src
    // Sources travel with the ID/EX tag; bubbles zero them so they match nothing
    assign idex_rs_d[gi] = hold_i      ? idex_rs_q[gi] :
                           idex_bubble ? '0            : id_rs[gi];

    // Youngest producer wins: EX/MEM before MEM/WB
    assign fwd_sel[gi] = tag_hits(exmem_tag, idex_rs_q[gi]) ? FWD_EX_MEM :
                         tag_hits(memwb_tag, idex_rs_q[gi]) ? FWD_MEM_WB : FWD_ID_EX;

`ifdef FWD_RF_BYPASS_EN
    // WB write data is passed through to the ID-stage register read
    assign rfbyp[gi] = tag_hits(memwb_tag, id_rs[gi]);
`else
    assign rfbyp[gi] = 1'b0;
`endif
  end

  // ID/EX source register fields, held and bubbled alongside the ID/EX tag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_rs_q <= '0;
    end else begin
      idex_rs_q <= idex_rs_d;
    end
  end

  // Load flags of the later stages play no part in forwarding
  logic unused_memread;
  assign unused_memread = exmem_tag.memread ^ memwb_tag.memread;

  assign forwardA_o = fwd_sel[0];
  assign forwardB_o = fwd_sel[1];
  assign stall_o    = stall;
  assign rfbypA_o   = rfbyp[0];
  assign rfbypB_o   = rfbyp[1];

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed instruction sequences,
// hand-derived expected selects pushed to a scoreboard queue per cycle and
// compared against the DUT outputs mid-cycle.
module tb_fwd_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       hold_i;
  logic       flush_i;
  logic       id_valid_i;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic [4:0] id_rd_i;
  logic       id_regwrite_i;
  logic       id_memread_i;
  logic [1:0] forwardA_o;
  logic [1:0] forwardB_o;
  logic       stall_o;
  logic       rfbypA_o;
  logic       rfbypB_o;

`ifdef FWD_RF_BYPASS_EN
  localparam bit RFB_ON = 1'b1;
`else
  localparam bit RFB_ON = 1'b0;
`endif

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       ra;
    logic       rb;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc_n = 0;

  always #5 clk_i = ~clk_i;

  fwd_hazard_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .hold_i        (hold_i),
    .flush_i       (flush_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .forwardA_o    (forwardA_o),
    .forwardB_o    (forwardB_o),
    .stall_o       (stall_o),
    .rfbypA_o      (rfbypA_o),
    .rfbypB_o      (rfbypB_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL cyc%0d %s: got %0h expected %0h", cyc_n, tag, got, exp);
    end
  endtask

  // One cycle: drive ID/control inputs, queue expectation, compare, advance
  task automatic cyc(input bit rst, input bit hold, input bit flush, input bit v,
                     input int rs1, input int rs2, input int rd, input bit rw, input bit mr,
                     input int fa, input int fb, input bit st, input bit ra, input bit rb);
    exp_t e;
    exp_t o;
    @(negedge clk_i);
    cyc_n++;
    rst_i         = rst;
    hold_i        = hold;
    flush_i       = flush;
    id_valid_i    = v;
    id_rs1_i      = 5'(rs1);
    id_rs2_i      = 5'(rs2);
    id_rd_i       = 5'(rd);
    id_regwrite_i = rw;
    id_memread_i  = mr;
    e.fa = 2'(fa);
    e.fb = 2'(fb);
    e.st = st;
    e.ra = ra & RFB_ON;
    e.rb = rb & RFB_ON;
    exp_q.push_back(e);
    #1;
    o = exp_q.pop_front();
    chk("forwardA", 32'(forwardA_o), 32'(o.fa));
    chk("forwardB", 32'(forwardB_o), 32'(o.fb));
    chk("stall",    32'(stall_o),    32'(o.st));
    chk("rfbypA",   32'(rfbypA_o),   32'(o.ra));
    chk("rfbypB",   32'(rfbypB_o),   32'(o.rb));
    $display("cyc%0d rst=%0b hold=%0b flush=%0b v=%0b rs1=%0d rs2=%0d rd=%0d -> fA=%0d fB=%0d st=%0b rA=%0b rB=%0b",
             cyc_n, rst, hold, flush, v, rs1, rs2, rd, forwardA_o, forwardB_o, stall_o, rfbypA_o, rfbypB_o);
  endtask

  task automatic nop(input int fa, input int fb);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb, 0, 0, 0);
  endtask

  initial begin
    rst_i = 1'b1; hold_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0;
    id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0; id_regwrite_i = 1'b0; id_memread_i = 1'b0;
    repeat (2) @(posedge clk_i);

    // Adjacent and two-apart dependences on x5
    cyc(0,0,0,1, 1,2, 5,1,0,  0,0,0,0,0);
    cyc(0,0,0,1, 5,3, 6,1,0,  0,0,0,0,0);
    nop(1,0);
    nop(0,0);
    cyc(0,0,0,1, 0,0, 5,1,0,  0,0,0,0,0);
    nop(0,0);
    cyc(0,0,0,1, 5,0, 8,1,0,  0,0,0,0,0);
    nop(2,0);

    // x5 in both EX/MEM and MEM/WB: EX/MEM wins
    cyc(0,0,0,1, 0,0, 5,1,0,  0,0,0,0,0);
    cyc(0,0,0,1, 0,0, 5,1,0,  0,0,0,0,0);
    cyc(0,0,0,1, 5,5,10,1,0,  0,0,0,0,0);
    nop(1,1);
    nop(0,0);
    nop(0,0);
    nop(0,0);

    // Load-use on x7: one stall, bubble, then MEM/WB forward on B
    cyc(0,0,0,1, 1,0, 7,1,1,  0,0,0,0,0);
    cyc(0,0,0,1, 3,7,11,1,0,  0,0,1,0,0);
    cyc(0,0,0,1, 3,7,11,1,0,  0,0,0,0,0);
    nop(0,2);
    nop(0,0);

    // x0 never forwards or stalls
    cyc(0,0,0,1, 0,0, 0,1,0,  0,0,0,0,0);
    cyc(0,0,0,1, 0,0,12,1,0,  0,0,0,0,0);
    cyc(0,0,0,1, 0,0, 0,1,1,  0,0,0,0,0);
    cyc(0,0,0,1, 0,0,13,1,0,  0,0,0,0,0);
    nop(0,0);
    nop(0,0);
    nop(0,0);

    // Hold for three cycles with a live EX/MEM forward
    cyc(0,0,0,1, 0,0, 5,1,0,  0,0,0,0,0);
    cyc(0,0,0,1, 5,0,14,1,0,  0,0,0,0,0);
    cyc(0,1,0,0, 0,0, 0,0,0,  1,0,0,0,0);
    cyc(0,1,0,0, 0,0, 0,0,0,  1,0,0,0,0);
    cyc(0,1,0,0, 0,0, 0,0,0,  1,0,0,0,0);
    nop(1,0);
    nop(0,0);

    // Flush coinciding with a load-use stall: exactly one bubble
    cyc(0,0,0,1, 0,0, 7,1,1,  0,0,0,0,0);
    cyc(0,0,1,1, 7,0,15,1,0,  0,0,1,0,0);
    nop(0,0);
    nop(0,0);

    // Reset with live tags clears everything at the next edge
    cyc(0,0,0,1, 0,0, 5,1,0,  0,0,0,0,0);
    cyc(0,0,0,1, 5,5,16,1,0,  0,0,0,0,0);
    cyc(1,0,0,1, 5,0,17,1,0,  1,1,0,0,0);
    nop(0,0);

    // WB-to-ID register-file bypass on x9
    cyc(0,0,0,1, 0,0, 9,1,0,  0,0,0,0,0);
    nop(0,0);
    nop(0,0);
    cyc(0,0,0,1, 9,3,17,1,0,  0,0,0,1,0);
    cyc(0,0,0,1, 0,9,18,1,0,  0,0,0,0,0);

    if (exp_q.size() != 0) chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
